// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and elaboration helpers for the bus master.
package i2s_pkg;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int frame_len(input int slot_bits);
    return 2 * slot_bits;
  endfunction

  function automatic bit params_legal(input int sample_size, input int slot_bits,
                                      input int bclk_half);
    return (sample_size >= 2) && (slot_bits >= sample_size + 1) && (bclk_half >= 1);
  endfunction

endpackage

// File: rtl/i2s_if.sv
// I2S master-side bus: sample handshake on the system side plus the serial pins.
interface i2s_if #(
  parameter int sample_size = 16
);
  // frame_strobe and rx_valid are one-clk pulses raised by the clk edge that
  // latched tx_l/tx_r and updated rx_l/rx_r; there is no back-pressure, so the
  // system side must present the next stereo pair before each frame start.
  logic                   enable;
  logic [sample_size-1:0] tx_l;
  logic [sample_size-1:0] tx_r;
  logic                   frame_strobe;
  logic                   din;
  logic                   bclk;
  logic                   lrclk;
  logic                   dout;
  logic [sample_size-1:0] rx_l;
  logic [sample_size-1:0] rx_r;
  logic                   rx_valid;

  modport master (
    input  enable, tx_l, tx_r, din,
    output frame_strobe, bclk, lrclk, dout, rx_l, rx_r, rx_valid
  );

  modport slave (
    output enable, tx_l, tx_r, din,
    input  frame_strobe, bclk, lrclk, dout, rx_l, rx_r, rx_valid
  );
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every bclk_half clk cycles and flags the edge.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int bclk_half = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int            DW       = (bclk_half > 1) ? $clog2(bclk_half) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(bclk_half - 1);

  logic [DW-1:0] div_ctr;
  logic          wrap;

  // Events are asserted in the cycle whose closing edge performs the toggle.
  assign wrap     = enable && (div_ctr == DIV_LAST);
  assign rise_evt = wrap && !bclk;
  assign fall_evt = wrap && bclk;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_ctr <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_ctr <= '0;
      bclk    <= ~bclk;
    end else begin
      div_ctr <= div_ctr + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_master.sv
// I2S bus master: owns bclk/lrclk, shifts a stereo pair out on dout and
// assembles the incoming stereo pair from din in Philips framing.
module i2s_master
  import i2s_pkg::*;
#(
  parameter int sample_size = 16,
  parameter int slot_bits   = 32,
  parameter int bclk_half   = 4
) (
  input logic clk,
  input logic reset,
  i2s_if.master bus
);

  localparam int            FRAME     = frame_len(slot_bits);
  localparam int            BW        = $clog2(FRAME);
  localparam int            IW        = $clog2(sample_size);
  localparam logic [BW-1:0] B_LAST    = BW'(FRAME - 1);
  localparam logic [BW-1:0] SLOT      = BW'(slot_bits);
  localparam logic [BW-1:0] SS_B      = BW'(sample_size);
  localparam bit            PARAMS_OK = params_legal(sample_size, slot_bits, bclk_half);

  logic                     rise_evt;
  logic                     fall_evt;
  logic [BW-1:0]            b;
  logic [BW-1:0]            b_next;
  logic [BW-1:0]            p_cur;
  logic [BW-1:0]            p_next;
  logic [BW-1:0]            bit_sel;
  logic [sample_size-1:0]   word;
  logic                     tx_bit;
  logic                     rx_take;
  logic [sample_size-1:0]   tx_l_lat;
  logic [sample_size-1:0]   tx_r_lat;
  logic [2*sample_size-1:0] rx_sr;
  logic                     primed;

  i2s_bclk_gen #(.bclk_half(bclk_half)) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .bclk     (bus.bclk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  function automatic logic [BW-1:0] slot_pos(input logic [BW-1:0] bv);
    return (bv >= SLOT) ? bv - SLOT : bv;
  endfunction

  assign b_next = (b == B_LAST) ? '0 : b + 1'b1;

  // dout is computed for the bit position the upcoming fall moves into.
  always_comb begin
    p_cur   = slot_pos(b);
    p_next  = slot_pos(b_next);
    bit_sel = SS_B - p_next;
    word    = (b_next >= SLOT) ? tx_r_lat : tx_l_lat;
    tx_bit  = (p_next != '0) && (p_next <= SS_B) && word[bit_sel[IW-1:0]];
    rx_take = rise_evt && (p_cur != '0) && (p_cur <= SS_B);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b                <= B_LAST;
      bus.lrclk        <= LEFT;
      bus.dout         <= 1'b0;
      bus.frame_strobe <= 1'b0;
      bus.rx_valid     <= 1'b0;
      bus.rx_l         <= '0;
      bus.rx_r         <= '0;
      primed           <= 1'b0;
      tx_l_lat         <= '0;
      tx_r_lat         <= '0;
      rx_sr            <= '0;
    end else if (!bus.enable) begin
      // Parked one position before frame start so the first fall opens a frame.
      b                <= B_LAST;
      bus.lrclk        <= LEFT;
      bus.dout         <= 1'b0;
      bus.frame_strobe <= 1'b0;
      bus.rx_valid     <= 1'b0;
      primed           <= 1'b0;
    end else begin
      bus.frame_strobe <= 1'b0;
      bus.rx_valid     <= 1'b0;
      if (rx_take) begin
        rx_sr <= {rx_sr[2*sample_size-2:0], bus.din};
      end
      if (fall_evt) begin
        b         <= b_next;
        bus.lrclk <= (b_next >= SLOT) ? RIGHT : LEFT;
        bus.dout  <= tx_bit;
        if (b_next == '0) begin
          tx_l_lat         <= bus.tx_l;
          tx_r_lat         <= bus.tx_r;
          bus.frame_strobe <= 1'b1;
          primed           <= 1'b1;
          // The frame just closed is only complete if we ran through all of it.
          if (primed) begin
            bus.rx_l     <= rx_sr[2*sample_size-1:sample_size];
            bus.rx_r     <= rx_sr[sample_size-1:0];
            bus.rx_valid <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (PARAMS_OK);
  end

endmodule

// File: tb/tb_i2s_master.sv
// Self-checking bench for i2s_master: cycle-level reference model derived from
// frame arithmetic, plus a loopback scoreboard of transmitted stereo pairs.
`timescale 1ns/1ps
module tb_i2s_master;

  localparam int SS    = 16;
  localparam int SLOT  = 32;
  localparam int H     = 4;
  localparam int FRAME = 2 * SLOT;
  localparam int FCLK  = FRAME * 2 * H;
  localparam int IW    = $clog2(SS);

  // clock / reset
  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic loop_mode = 1'b1;
  logic din_rand  = 1'b0;

  i2s_if #(.sample_size(SS)) bus ();
  assign bus.din = loop_mode ? bus.dout : din_rand;

  i2s_master #(.sample_size(SS), .slot_bits(SLOT), .bclk_half(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // counters and scoreboard
  int n_checks    = 0;
  int n_pass      = 0;
  int n_loop_pops = 0;
  logic [2*SS-1:0] exp_q[$];

  // reference model state
  int          t      = 0;
  int          frames = 0;
  logic [SS-1:0] m_txl = '0, m_txr = '0, m_rx_l = '0, m_rx_r = '0;
  logic [SS-1:0] cap_l = '0, cap_r = '0;
  logic        exp_strobe = 1'b0, exp_valid = 1'b0;
  logic        a_rst, a_en, a_loop, din_last;
  logic [SS-1:0] a_txl, a_txr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int cur_b();
    int f;
    f = (t / H) / 2;
    return (f == 0) ? -1 : (f - 1) % FRAME;
  endfunction

  // Advance the model over the posedge that just happened.
  task automatic model_step();
    int n, f, b, p;
    exp_strobe = 1'b0;
    exp_valid  = 1'b0;
    if (a_rst) begin
      t = 0; frames = 0;
      m_rx_l = '0; m_rx_r = '0; m_txl = '0; m_txr = '0;
      exp_q.delete();
    end else if (!a_en) begin
      t = 0; frames = 0;
      exp_q.delete();
    end else begin
      t++;
      if (t % H == 0) begin
        n = t / H;
        if (n % 2 == 1) begin
          f = (n - 1) / 2;
          b = (f == 0) ? FRAME - 1 : (f - 1) % FRAME;
          p = b % SLOT;
          if (p >= 1 && p <= SS) begin
            if (b < SLOT) cap_l[IW'(SS - p)] = din_last;
            else          cap_r[IW'(SS - p)] = din_last;
          end
        end else begin
          f = n / 2;
          b = (f - 1) % FRAME;
          if (b == 0) begin
            exp_strobe = 1'b1;
            if (frames >= 1) begin
              m_rx_l = cap_l; m_rx_r = cap_r; exp_valid = 1'b1;
            end
            frames++;
            m_txl = a_txl; m_txr = a_txr;
          end
        end
      end
    end
  endtask

  task automatic compare();
    int n, f, b, p;
    logic e_bclk, e_lr, e_dout;
    logic [SS-1:0] w;
    logic [2*SS-1:0] pair;
    n = t / H;
    f = n / 2;
    e_bclk = (n % 2) == 1;
    e_lr = 1'b0;
    e_dout = 1'b0;
    if (f > 0) begin
      b = (f - 1) % FRAME;
      e_lr = (b >= SLOT);
      p = b % SLOT;
      w = e_lr ? m_txr : m_txl;
      if (p >= 1 && p <= SS) e_dout = w[IW'(SS - p)];
    end
    check("bclk", bus.bclk, e_bclk);
    check("lrclk", bus.lrclk, e_lr);
    check("dout", bus.dout, e_dout);
    check("frame_strobe", bus.frame_strobe, exp_strobe);
    check("rx_valid", bus.rx_valid, exp_valid);
    check("rx_l", bus.rx_l, m_rx_l);
    check("rx_r", bus.rx_r, m_rx_r);
    if (exp_valid && a_loop && exp_q.size() > 0) begin
      pair = exp_q.pop_front();
      n_loop_pops++;
      check("loop_rx_l", bus.rx_l, pair[2*SS-1:SS]);
      check("loop_rx_r", bus.rx_r, pair[SS-1:0]);
    end
    if (exp_strobe && a_loop) exp_q.push_back({m_txl, m_txr});
  endtask

  // driver tasks
  task automatic cycle();
    din_rand = 1'($urandom_range(0, 1));
    a_rst    = reset;
    a_en     = bus.enable;
    a_txl    = bus.tx_l;
    a_txr    = bus.tx_r;
    a_loop   = loop_mode;
    din_last = loop_mode ? bus.dout : din_rand;
    @(negedge clk);
    model_step();
    compare();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic wait_b(input int target);
    int k;
    k = 0;
    while (cur_b() != target && k < 2 * FCLK) begin
      cycle();
      k++;
    end
    check("wait_b_bound", cur_b(), target);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.tx_l   = 16'hA5C3;
    bus.tx_r   = 16'h1234;
    reset      = 1'b1;
    run(3);
    reset      = 1'b0;
    bus.enable = 1'b1;
    run(3 * FCLK);

    // tx change inside a frame only affects the next frame
    wait_b(10);
    bus.tx_l = 16'hFFFF;
    run(2 * FCLK);

    // one-cycle reset in the middle of the left... right slot
    wait_b(40);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(2 * FCLK + 20);

    // enable drop mid-frame keeps rx words until the next valid frame
    bus.tx_l = 16'h0F0F;
    wait_b(20);
    bus.enable = 1'b0;
    run(50);
    bus.enable = 1'b1;
    run(3 * FCLK);

    // random din, random tx timing, occasional enable blips
    bus.enable = 1'b0;
    run(4);
    loop_mode  = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 4 * FCLK; i++) begin
      if ($urandom_range(0, 63) == 0) bus.tx_l = SS'($urandom);
      if ($urandom_range(0, 63) == 0) bus.tx_r = SS'($urandom);
      if (!bus.enable && $urandom_range(0, 7) == 0) bus.enable = 1'b1;
      else if (bus.enable && $urandom_range(0, 2999) == 0) bus.enable = 1'b0;
      cycle();
    end

    // loopback with random words
    bus.enable = 1'b0;
    run(4);
    loop_mode  = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 4 * FCLK; i++) begin
      if ($urandom_range(0, 127) == 0) begin
        bus.tx_l = SS'($urandom);
        bus.tx_r = SS'($urandom);
      end
      cycle();
    end

    check("loop_pops_seen", 32'(n_loop_pops > 6), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
